// File: rtl/spi_pkg.sv
// Shared definitions for the SPI word master.
// Contents: FSM state enum, SPI mode constants, mode decode helpers and the
// nbytes port width helper.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    // {CPOL,CPHA}
    localparam int SPI_MODE_0 = 0;
    localparam int SPI_MODE_1 = 1;
    localparam int SPI_MODE_2 = 2;
    localparam int SPI_MODE_3 = 3;

    // Width of the byte-count-minus-one field; never below 1 bit.
    function automatic int nbytes_w(input int data_w);
        if (data_w / 8 > 1) return $clog2(data_w / 8);
        return 1;
    endfunction

    function automatic logic mode_cpol(input int mode);
        return mode[1];
    endfunction

    function automatic logic mode_cpha(input int mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_edge_gen.sv
// SPI clock generator.
// Ports:
//   clk, reset     - system clock, async active-high reset
//   en_i           - run enable from the FSM; low parks sclk at CPOL
//   sclk_o         - registered SPI clock
//   lead_edge_o    - high in the cycle whose closing clk edge makes sclk leave idle
//   trail_edge_o   - high in the cycle whose closing clk edge returns sclk to idle
// The strobes announce the edge one cycle ahead, so the FSM can update mosi
// on the same clk edge that moves sclk.
module spi_edge_gen #(
    parameter int H    = 2,
    parameter int CPOL = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic sclk_o,
    output logic lead_edge_o,
    output logic trail_edge_o
);
    localparam int   HW       = (H > 1) ? $clog2(H) : 1;
    localparam logic IDLE_LVL = CPOL[0];

    logic [HW-1:0] cnt_q;
    logic          sclk_q;
    logic          tick;

    assign tick         = en_i && (cnt_q == HW'(H - 1));
    assign lead_edge_o  = tick && (sclk_q == IDLE_LVL);
    assign trail_edge_o = tick && (sclk_q != IDLE_LVL);
    assign sclk_o       = sclk_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            sclk_q <= IDLE_LVL;
        end else if (!en_i) begin
            cnt_q  <= '0;
            sclk_q <= IDLE_LVL;
        end else if (tick) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q  <= cnt_q + HW'(1);
        end
    end
endmodule

// File: rtl/spi_word_master.sv
// Full-duplex SPI master moving a 1..DATA_W/8-byte word in one cs_n frame.
// Ports:
//   clk, reset          - system clock, async active-high reset
//   start, nbytes, din  - transfer request; nbytes = byte count - 1
//   cs_hold             - (SPI_WORD_MASTER_CS_HOLD_EN only) keep frame open
//   dout, dout_valid    - right-justified receive word and its 1-cycle strobe
//   busy                - transfer or inter-frame gap in progress
//   cs_n, sclk, mosi    - SPI pins out; miso - SPI pin in
// Macro SPI_WORD_MASTER_CS_HOLD_EN adds the cs_hold port: a held frame ends
// in IDLE with cs_n still low and the next start skips SETUP.
module spi_word_master
    import spi_pkg::*;
#(
    parameter int DATA_W            = 32,
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
`ifdef SPI_WORD_MASTER_CS_HOLD_EN
    input  logic                        cs_hold,
`endif
    input  logic [nbytes_w(DATA_W)-1:0] nbytes,
    input  logic [DATA_W-1:0]           din,
    output logic [DATA_W-1:0]           dout,
    output logic                        dout_valid,
    output logic                        busy,
    output logic                        cs_n,
    output logic                        sclk,
    output logic                        mosi,
    input  logic                        miso
);
    localparam int   H     = CLKS_PER_HALF_BIT;
    localparam int   NBW   = nbytes_w(DATA_W);
    localparam int   BW    = $clog2(DATA_W + 1);
    localparam int   EW    = $clog2(2 * DATA_W + 1);
    localparam int   CW    = $clog2(2 * H * DATA_W + 1);
    localparam int   MAXNB = DATA_W / 8 - 1;
    localparam logic CPHA  = mode_cpha(SPI_MODE);

    spi_state_e        state_q, state_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [BW-1:0]     nbits_q;
    logic [EW-1:0]     edges_q;
    logic [DATA_W-1:0] tx_q, rx_q, dout_q;
    logic              valid_q, valid_d, busy_q, cs_n_q, cs_n_d;
    logic              cont_q, cont_d, hold_q, load;
    logic              gen_en, lead, trail, sample_en, drive_en;

    logic [NBW-1:0]    nb_c;
    logic [BW-1:0]     nbits_new;
    logic [DATA_W-1:0] tx_new;
    logic [CW-1:0]     shift_last;

    // Out-of-range byte counts (non-power-of-two widths) saturate to DATA_W.
    always_comb begin
        nb_c = nbytes;
        if (int'(nbytes) > MAXNB) nb_c = NBW'(MAXNB);
    end
    assign nbits_new  = BW'((int'(nb_c) + 1) * 8);
    // Left-align the active bits so mosi is always the shift register MSB.
    assign tx_new     = din << (DATA_W - int'(nbits_new));
    assign shift_last = CW'(2 * H * int'(nbits_q) - 1);

    // sclk runs through SETUP so its first edge lands on the SHIFT entry edge;
    // it stops once all 2N edges are out, leaving an idle tail in SHIFT.
    assign gen_en    = ((state_q == SETUP) || (state_q == SHIFT)) &&
                       (edges_q != EW'(2 * int'(nbits_q)));
    assign sample_en = CPHA ? trail : lead;
    // With CPHA=1 the first bit is already on mosi from load time.
    assign drive_en  = CPHA ? (lead && (edges_q != '0)) : trail;

    spi_edge_gen #(.H(H), .CPOL(int'(mode_cpol(SPI_MODE)))) u_edge (
        .clk          (clk),
        .reset        (reset),
        .en_i         (gen_en),
        .sclk_o       (sclk),
        .lead_edge_o  (lead),
        .trail_edge_o (trail)
    );

`ifdef SPI_WORD_MASTER_CS_HOLD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     hold_q <= 1'b0;
        else if (load) hold_q <= cs_hold;
    end
`else
    assign hold_q = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q + CW'(1);
        cont_d  = cont_q;
        valid_d = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                cyc_d = '0;
                if (start) begin
                    load    = 1'b1;
                    state_d = cont_q ? SHIFT : SETUP;
                end
            end
            SETUP: if (cyc_q == CW'(H - 1)) begin
                state_d = SHIFT;
                cyc_d   = '0;
            end
            SHIFT: if (cyc_q == shift_last) begin
                state_d = HOLD;
                cyc_d   = '0;
            end
            HOLD: if (cyc_q == CW'(H - 1)) begin
                valid_d = 1'b1;
                cyc_d   = '0;
                cont_d  = hold_q;
                state_d = hold_q ? IDLE : GAP;
            end
            GAP: if (cyc_q == CW'(H - 1)) begin
                state_d = IDLE;
                cyc_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        cs_n_d = 1'b1;
        if ((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD)) cs_n_d = 1'b0;
        if ((state_d == IDLE) && cont_d) cs_n_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            cont_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            cont_q  <= cont_d;
            valid_q <= valid_d;
            busy_q  <= (state_d != IDLE);
            cs_n_q  <= cs_n_d;
            if (valid_d) dout_q <= rx_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_q    <= '0;
            rx_q    <= '0;
            nbits_q <= BW'(8);
            edges_q <= '0;
        end else if (load) begin
            tx_q    <= tx_new;
            rx_q    <= '0;
            nbits_q <= nbits_new;
            edges_q <= '0;
        end else begin
            if (lead || trail) edges_q <= edges_q + EW'(1);
            if (sample_en)     rx_q    <= {rx_q[DATA_W-2:0], miso};
            if (drive_en)      tx_q    <= {tx_q[DATA_W-2:0], 1'b0};
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = busy_q;
    assign cs_n       = cs_n_q;
    assign mosi       = tx_q[DATA_W-1];
endmodule

// File: tb/tb_spi_word_master.sv
module tb_spi_word_master;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    // A: mode 0, H=2, loopback.  B: mode 3, H=1, 8-bit slave model.
    logic        start_a = 0, start_b = 0;
    logic [1:0]  nbytes_a = 0, nbytes_b = 0;
    logic [31:0] din_a = 0, din_b = 0, dout_a, dout_b;
    logic        dv_a, dv_b, busy_a, busy_b, cs_n_a, cs_n_b;
    logic        sclk_a, sclk_b, mosi_a, mosi_b, miso_a;
    logic        miso_b = 1'b0;
`ifdef SPI_WORD_MASTER_CS_HOLD_EN
    logic        cs_hold_a = 1'b0, cs_hold_b = 1'b0;
`endif

    assign miso_a = mosi_a;

    spi_word_master #(.DATA_W(32), .SPI_MODE(0), .CLKS_PER_HALF_BIT(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
`ifdef SPI_WORD_MASTER_CS_HOLD_EN
        .cs_hold(cs_hold_a),
`endif
        .nbytes(nbytes_a), .din(din_a), .dout(dout_a), .dout_valid(dv_a),
        .busy(busy_a), .cs_n(cs_n_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a));

    spi_word_master #(.DATA_W(32), .SPI_MODE(3), .CLKS_PER_HALF_BIT(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
`ifdef SPI_WORD_MASTER_CS_HOLD_EN
        .cs_hold(cs_hold_b),
`endif
        .nbytes(nbytes_b), .din(din_b), .dout(dout_b), .dout_valid(dv_b),
        .busy(busy_b), .cs_n(cs_n_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b));

    // Mode 3 slave: drives the next bit of its pattern on each falling sclk.
    logic [7:0] slv_pat = 8'h3C;
    int         sidx = 7;
    always @(negedge sclk_b or posedge cs_n_b) begin
        if (cs_n_b) sidx <= 7;
        else begin
            miso_b <= slv_pat[sidx];
            sidx   <= sidx - 1;
        end
    end

    int n_cmp = 0, n_bad = 0;
    logic [31:0] exp_q[$], got_q[$];

    // Drive one transfer and record what the pins did; cycle 1 is the cycle
    // after the one in which start was high.
    task automatic run_frame(input bit sel, input logic [31:0] d, input logic [1:0] nb,
                             input int restart_at, output int vcyc, output int bfall,
                             output int pulses, output logic [31:0] mbits, output int nval,
                             output bit cs_hi, output bit cs_at_v, output bit tmo);
        logic cpol, prev, sc, cn, bz, mo, dv;
        logic [31:0] dq;
        cpol = sel; prev = cpol;
        vcyc = -1; bfall = -1; pulses = 0; mbits = 0; nval = 0;
        cs_hi = 0; cs_at_v = 0; tmo = 1;
        @(negedge clk);
        if (sel) begin din_b = d; nbytes_b = nb; start_b = 1; end
        else     begin din_a = d; nbytes_a = nb; start_a = 1; end
        for (int c = 1; c <= 600; c++) begin
            @(posedge clk); #1;
            start_a = 0; start_b = 0;
            if (c == restart_at) begin din_a = ~d; nbytes_a = 0; start_a = 1; end
            sc = sel ? sclk_b : sclk_a;   cn = sel ? cs_n_b : cs_n_a;
            bz = sel ? busy_b : busy_a;   mo = sel ? mosi_b : mosi_a;
            dv = sel ? dv_b : dv_a;       dq = sel ? dout_b : dout_a;
            if (sc != cpol && prev == cpol) begin
                pulses++;
                mbits = {mbits[30:0], mo};
            end
            prev = sc;
            if (dv) begin nval++; vcyc = c; cs_at_v = cn; got_q.push_back(dq); end
            else if (cn && nval == 0) cs_hi = 1;
            if (!bz) begin bfall = c; tmo = 0; break; end
        end
        start_a = 0;
    endtask

    task automatic test_reset();
        n_cmp++; if (cs_n_a !== 1'b1) begin n_bad++; $display("FAIL rst_cs_n: got %b want 1", cs_n_a); end
        n_cmp++; if (sclk_a !== 1'b0) begin n_bad++; $display("FAIL rst_sclk_a: got %b want 0", sclk_a); end
        n_cmp++; if (sclk_b !== 1'b1) begin n_bad++; $display("FAIL rst_sclk_b: got %b want 1", sclk_b); end
        n_cmp++; if (mosi_a !== 1'b0) begin n_bad++; $display("FAIL rst_mosi: got %b want 0", mosi_a); end
        n_cmp++; if (dout_a !== 32'h0) begin n_bad++; $display("FAIL rst_dout: got %h want 0", dout_a); end
        n_cmp++; if (dv_a !== 1'b0 || busy_a !== 1'b0) begin
            n_bad++; $display("FAIL rst_dv_busy: got %b%b want 00", dv_a, busy_a); end
    endtask

    task automatic check_frame(input string nm, input int vcyc, input int bfall, input int pulses,
                               input logic [31:0] mbits, input int nval, input bit cs_hi,
                               input bit cs_at_v, input bit tmo, input int e_v, input int e_b,
                               input int e_p, input logic [31:0] e_m);
        logic [31:0] e, g;
        n_cmp++; if (tmo) begin n_bad++; $display("FAIL %s_timeout: busy never fell", nm); end
        n_cmp++; if (nval != 1) begin n_bad++; $display("FAIL %s_nvalid: got %0d want 1", nm, nval); end
        n_cmp++; if (vcyc != e_v) begin n_bad++; $display("FAIL %s_vcyc: got %0d want %0d", nm, vcyc, e_v); end
        n_cmp++; if (bfall != e_b) begin n_bad++; $display("FAIL %s_busy_fall: got %0d want %0d", nm, bfall, e_b); end
        n_cmp++; if (pulses != e_p) begin n_bad++; $display("FAIL %s_pulses: got %0d want %0d", nm, pulses, e_p); end
        n_cmp++; if (mbits !== e_m) begin n_bad++; $display("FAIL %s_mosi: got %h want %h", nm, mbits, e_m); end
        n_cmp++; if (cs_hi || !cs_at_v) begin
            n_bad++; $display("FAIL %s_cs_n: high_early=%0d at_valid=%0d want 0/1", nm, cs_hi, cs_at_v); end
        e = exp_q.size() ? exp_q.pop_front() : 32'hx;
        n_cmp++;
        if (got_q.size() == 0) begin n_bad++; $display("FAIL %s_dout: got none want %h", nm, e); end
        else begin
            g = got_q.pop_front();
            if (g !== e) begin n_bad++; $display("FAIL %s_dout: got %h want %h", nm, g, e); end
        end
    endtask

    task automatic test_loopback();
        int v, b, p, n; logic [31:0] m; bit ch, cv, t;
        exp_q.push_back(32'hA5C30F96);
        run_frame(0, 32'hA5C30F96, 2'd3, -1, v, b, p, m, n, ch, cv, t);
        check_frame("lb32", v, b, p, m, n, ch, cv, t, 133, 135, 32, 32'hA5C30F96);
        exp_q.push_back(32'h00000078);
        run_frame(0, 32'h12345678, 2'd0, -1, v, b, p, m, n, ch, cv, t);
        check_frame("lb8", v, b, p, m, n, ch, cv, t, 37, 39, 8, 32'h00000078);
    endtask

    task automatic test_mode3();
        int v, b, p, n; logic [31:0] m; bit ch, cv, t;
        exp_q.push_back(32'h0000003C);
        run_frame(1, 32'h000000C3, 2'd0, -1, v, b, p, m, n, ch, cv, t);
        check_frame("m3", v, b, p, m, n, ch, cv, t, 19, 20, 8, 32'h000000C3);
        n_cmp++; if (sclk_b !== 1'b1) begin n_bad++; $display("FAIL m3_idle_sclk: got %b want 1", sclk_b); end
    endtask

    task automatic test_start_ignored();
        int v, b, p, n; logic [31:0] m; bit ch, cv, t;
        exp_q.push_back(32'h5AF0C381);
        run_frame(0, 32'h5AF0C381, 2'd3, 10, v, b, p, m, n, ch, cv, t);
        check_frame("ign", v, b, p, m, n, ch, cv, t, 133, 135, 32, 32'h5AF0C381);
    endtask

    task automatic test_back_to_back();
        int v, b, p, n; logic [31:0] m, d1, d2; bit ch, cv, t;
        d1 = $urandom; d2 = {16'h0, 16'($urandom)};
        exp_q.push_back(d1);
        run_frame(0, d1, 2'd3, -1, v, b, p, m, n, ch, cv, t);
        check_frame("b2b1", v, b, p, m, n, ch, cv, t, 133, 135, 32, d1);
        exp_q.push_back(d2);
        run_frame(0, 32'hFFFF0000 | d2, 2'd1, -1, v, b, p, m, n, ch, cv, t);
        check_frame("b2b2", v, b, p, m, n, ch, cv, t, 69, 71, 16, d2);
    endtask

    task automatic test_reset_mid();
        int v, b, p, n, nv; logic [31:0] m; bit ch, cv, t;
        nv = 0;
        @(negedge clk); din_a = 32'hDEADBEEF; nbytes_a = 2'd3; start_a = 1;
        @(posedge clk); #1 start_a = 0;
        for (int c = 0; c < 50; c++) begin @(posedge clk); #1 if (dv_a) nv++; end
        reset = 1;
        @(posedge clk); #1;
        if (dv_a) nv++;
        n_cmp++; if (cs_n_a !== 1'b1 || sclk_a !== 1'b0 || busy_a !== 1'b0) begin
            n_bad++; $display("FAIL rmid_pins: cs_n/sclk/busy got %b%b%b want 100", cs_n_a, sclk_a, busy_a); end
        n_cmp++; if (dout_a !== 32'h0 || mosi_a !== 1'b0) begin
            n_bad++; $display("FAIL rmid_regs: dout %h mosi %b want 0/0", dout_a, mosi_a); end
        @(negedge clk); reset = 0;
        @(posedge clk); #1 if (dv_a) nv++;
        n_cmp++; if (nv != 0) begin n_bad++; $display("FAIL rmid_no_valid: got %0d want 0", nv); end
        exp_q.push_back(32'h0000C3A5);
        run_frame(0, 32'h1234C3A5, 2'd1, -1, v, b, p, m, n, ch, cv, t);
        check_frame("rmid_new", v, b, p, m, n, ch, cv, t, 69, 71, 16, 32'h0000C3A5);
    endtask

`ifdef SPI_WORD_MASTER_CS_HOLD_EN
    task automatic test_cs_hold();
        int v1, b1, p1, n1, v2, b2, p2, n2; logic [31:0] m1, m2; bit ch1, cv1, t1, ch2, cv2, t2;
        logic [31:0] g;
        cs_hold_a = 1;
        run_frame(0, 32'h0000ABCD, 2'd1, -1, v1, b1, p1, m1, n1, ch1, cv1, t1);
        cs_hold_a = 0;
        run_frame(0, 32'h00001234, 2'd1, -1, v2, b2, p2, m2, n2, ch2, cv2, t2);
        n_cmp++; if (t1 || t2 || n1 != 1 || n2 != 1) begin
            n_bad++; $display("FAIL hold_valids: got %0d,%0d tmo %0d%0d want 1,1", n1, n2, t1, t2); end
        n_cmp++; if (p1 + p2 != 32 || m1[15:0] !== 16'hABCD || m2[15:0] !== 16'h1234) begin
            n_bad++; $display("FAIL hold_pulses: got %0d mosi %h/%h want 32 abcd/1234", p1 + p2, m1, m2); end
        n_cmp++; if (ch1 || cv1 || ch2 || cs_n_a !== 1'b1) begin
            n_bad++; $display("FAIL hold_cs_n: got %0d%0d%0d end %b want 0001", ch1, cv1, ch2, cs_n_a); end
        n_cmp++; if (v1 != 69 || b1 != 69 || v2 != 67 || b2 != 69) begin
            n_bad++; $display("FAIL hold_timing: got %0d/%0d %0d/%0d want 69/69 67/69", v1, b1, v2, b2); end
        n_cmp++;
        if (got_q.size() != 2) begin n_bad++; $display("FAIL hold_dout: got %0d words want 2", got_q.size()); end
        else begin
            g = got_q.pop_front();
            if (g !== 32'h0000ABCD) begin n_bad++; $display("FAIL hold_dout1: got %h want 0000abcd", g); end
            g = got_q.pop_front();
            if (g !== 32'h00001234) begin n_bad++; $display("FAIL hold_dout2: got %h want 00001234", g); end
        end
    endtask
`endif

    initial begin
        repeat (3) @(posedge clk);
        #1 test_reset();
        @(negedge clk) reset = 0;
        test_loopback();
        test_mode3();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
`ifdef SPI_WORD_MASTER_CS_HOLD_EN
        test_cs_hold();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
